// File: rtl/topk_pkg.sv
// Shared types and constants for the streaming top-K tracker.
package topk_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUBN = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_MAX  = 3'd4,
        OP_MIN  = 3'd5,
        OP_RORA = 3'd6,
        OP_ROLA = 3'd7
    } fu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [2:0] SEL_BC = 3'b011;
    localparam logic [2:0] SEL_AC = 3'b101;
    localparam logic [2:0] SEL_AB = 3'b110;

endpackage

// File: rtl/fu_param.sv
// Combinational functional unit: opcode priority encode, operand pair mux and op datapath.
module fu_param
    import topk_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    input  logic [W-1:0] data_c,
    input  logic [7:0]   instruction,
    input  logic [2:0]   select,
    input  logic         signed_mode,
    output logic [W-1:0] result
);

    fu_op_e       op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         x_gt_y;

    // Highest set bit wins; an all-zero opcode falls back to add.
    always_comb begin
        op = OP_ADD;
        for (int i = 0; i < 8; i++) begin
            if (instruction[i]) op = fu_op_e'(i[2:0]);
        end
    end

    always_comb begin
        case (select)
            SEL_BC:  begin x = data_b; y = data_c; end
            SEL_AC:  begin x = data_a; y = data_c; end
            SEL_AB:  begin x = data_a; y = data_b; end
            default: begin x = data_c; y = data_a; end
        endcase
    end

    // Flipping the sign bit turns a two's-complement compare into an unsigned one.
    assign x_gt_y = {x[W-1] ^ signed_mode, x[W-2:0]} > {y[W-1] ^ signed_mode, y[W-2:0]};

    always_comb begin
        case (op)
            OP_ROLA: result = {x[W-2:0], x[W-1]} + y;
            OP_RORA: result = {x[0], x[W-1:1]} + y;
            OP_MIN:  result = x_gt_y ? y : x;
            OP_MAX:  result = x_gt_y ? x : y;
            OP_OR:   result = x | y;
            OP_AND:  result = x & y;
            OP_SUBN: result = x + ~y;
            default: result = x + y;
        endcase
    end

endmodule

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: run sequencing, remaining-sample counter and sorted rank array.
//   state   | meaning
//   ST_IDLE | waiting for start; ranks from last run held
//   ST_RUN  | accepting valid samples until remaining reaches zero
module topk_tracker
    import topk_pkg::*;
#(
    parameter int W     = 8,
    parameter int K     = 2,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             signed_mode,
    input  logic             valid,
    input  logic [W-1:0]     data_a,
    input  logic [W-1:0]     data_b,
    input  logic [W-1:0]     data_c,
    input  logic [7:0]       instruction,
    input  logic [2:0]       select,
    output logic             busy,
    output logic             done,
    output logic [K*W-1:0]   rank_out,
    output logic [K-1:0]     rank_vld
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q;
    logic             mode_q;
    logic             done_q, done_d;
    logic             clr, load, ins;
    logic [W-1:0]     fu_res;

    logic [K-1:0][W-1:0] rank_q, rank_d;
    logic [K-1:0]        vld_q, vld_d;
    logic [K-1:0]        beats;
    logic [K:0]          beat_up;
    logic [K:0][W-1:0]   val_up;
    logic [K:0]          vld_up;

    fu_param #(.W(W)) u_fu (
        .data_a      (data_a),
        .data_b      (data_b),
        .data_c      (data_c),
        .instruction (instruction),
        .select      (select),
        .signed_mode (mode_q),
        .result      (fu_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                rem_q  <= count;
                mode_q <= signed_mode;
            end else if (ins) begin
                rem_q <= rem_q - CNT_W'(1);
            end
        end
    end

    // start takes priority over valid in both states, so a restart drops that cycle's sample.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        load    = 1'b0;
        ins     = 1'b0;
        done_d  = 1'b0;
        if (start) begin
            clr  = 1'b1;
            load = 1'b1;
            if (count == '0) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN && valid) begin
            ins = 1'b1;
            if (rem_q == CNT_W'(1)) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    assign beat_up[0] = 1'b0;
    assign val_up[0]  = '0;
    assign vld_up[0]  = 1'b0;

    // Each slot either shifts down from the slot above, captures the new result, or holds.
    for (genvar i = 0; i < K; i++) begin : g_slot
        assign beats[i] = !vld_q[i] ||
            ({fu_res[W-1] ^ mode_q, fu_res[W-2:0]} > {rank_q[i][W-1] ^ mode_q, rank_q[i][W-2:0]});
        assign beat_up[i+1] = beats[i];
        assign val_up[i+1]  = rank_q[i];
        assign vld_up[i+1]  = vld_q[i];
        assign rank_d[i] = beat_up[i] ? val_up[i] : (beats[i] ? fu_res : rank_q[i]);
        assign vld_d[i]  = beat_up[i] ? vld_up[i] : (beats[i] | vld_q[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rank_q <= '0;
            vld_q  <= '0;
        end else if (ins) begin
            rank_q <= rank_d;
            vld_q  <= vld_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign rank_out = rank_q;
    assign rank_vld = vld_q;

endmodule

// File: tb/tb_topk_tracker.sv
// Directed self-checking bench for topk_tracker, with a K=2 and a K=3 instance on shared stimulus.
module tb_topk_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  count;
    logic        signed_mode;
    logic        valid;
    logic [7:0]  data_a, data_b, data_c;
    logic [7:0]  instruction;
    logic [2:0]  select;

    logic        busy2, done2, busy3, done3;
    logic [15:0] rank_out2;
    logic [1:0]  rank_vld2;
    logic [23:0] rank_out3;
    logic [2:0]  rank_vld3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    topk_tracker #(.W(8), .K(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .signed_mode(signed_mode),
        .valid(valid), .data_a(data_a), .data_b(data_b), .data_c(data_c),
        .instruction(instruction), .select(select),
        .busy(busy2), .done(done2), .rank_out(rank_out2), .rank_vld(rank_vld2)
    );

    topk_tracker #(.W(8), .K(3), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .signed_mode(signed_mode),
        .valid(valid), .data_a(data_a), .data_b(data_b), .data_c(data_c),
        .instruction(instruction), .select(select),
        .busy(busy3), .done(done3), .rank_out(rank_out3), .rank_vld(rank_vld3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [2:0] cnt, input logic sgn);
        start = 1'b1; count = cnt; signed_mode = sgn; valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic sample(input logic [7:0] a, input logic [7:0] b);
        valid = 1'b1; data_a = a; data_b = b;
        tick();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; count = '0; signed_mode = 1'b0; valid = 1'b0;
        data_a = '0; data_b = '0; data_c = '0; instruction = '0; select = '0;
        tick(); tick();
        checks++; if ({busy2, done2, busy3, done3} !== 4'b0) begin failures++;
            $display("FAIL reset_ctl got=%b want=0000", {busy2, done2, busy3, done3}); end
        checks++; if (rank_out2 !== 16'h0 || rank_vld2 !== 2'b0) begin failures++;
            $display("FAIL reset_rank2 got=%h/%b want=0000/00", rank_out2, rank_vld2); end
        checks++; if (rank_out3 !== 24'h0 || rank_vld3 !== 3'b0) begin failures++;
            $display("FAIL reset_rank3 got=%h/%b want=000000/000", rank_out3, rank_vld3); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        instruction = 8'h01; select = 3'b110;
        run_start(3'd4, 1'b0);
        checks++; if (busy2 !== 1'b1 || rank_vld2 !== 2'b00) begin failures++;
            $display("FAIL add_start got busy=%b vld=%b want 1/00", busy2, rank_vld2); end
        sample(8'd5, 8'd5);
        sample(8'd10, 8'd20);
        sample(8'd15, 8'd5);
        checks++; if (rank_out2 !== {8'd20, 8'd30} || done2 !== 1'b0 || busy2 !== 1'b1) begin failures++;
            $display("FAIL add_mid got=%h done=%b busy=%b want=141e 0 1", rank_out2, done2, busy2); end
        sample(8'd30, 8'd0);
        checks++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin failures++;
            $display("FAIL add_done got done=%b busy=%b want 1/0", done2, busy2); end
        checks++; if (rank_out2 !== {8'd30, 8'd30} || rank_vld2 !== 2'b11) begin failures++;
            $display("FAIL add_rank2 got=%h/%b want=1e1e/11", rank_out2, rank_vld2); end
        checks++; if (rank_out3 !== {8'd20, 8'd30, 8'd30} || rank_vld3 !== 3'b111) begin failures++;
            $display("FAIL add_rank3 got=%h/%b want=141e1e/111", rank_out3, rank_vld3); end
        tick();
        checks++; if (done2 !== 1'b0 || rank_out2 !== {8'd30, 8'd30}) begin failures++;
            $display("FAIL add_persist got done=%b rank=%h want 0/1e1e", done2, rank_out2); end
    endtask

    task automatic test_signed();
        instruction = 8'h10; select = 3'b110;
        run_start(3'd3, 1'b1);
        sample(8'hFB, 8'h80);
        sample(8'h03, 8'h80);
        sample(8'hFF, 8'h80);
        checks++; if (done3 !== 1'b1 || rank_out3 !== {8'hFB, 8'hFF, 8'h03}) begin failures++;
            $display("FAIL signed_rank3 got=%h done=%b want=fbff03 1", rank_out3, done3); end
        checks++; if (rank_out2 !== {8'hFF, 8'h03}) begin failures++;
            $display("FAIL signed_rank2 got=%h want=ff03", rank_out2); end
        run_start(3'd3, 1'b0);
        sample(8'hFB, 8'hFB);
        sample(8'h03, 8'h03);
        sample(8'hFF, 8'hFF);
        checks++; if (rank_out3 !== {8'h03, 8'hFB, 8'hFF} || rank_vld3 !== 3'b111) begin failures++;
            $display("FAIL unsigned_rank3 got=%h/%b want=03fbff/111", rank_out3, rank_vld3); end
        checks++; if (rank_out2 !== {8'hFB, 8'hFF}) begin failures++;
            $display("FAIL unsigned_rank2 got=%h want=fbff", rank_out2); end
    endtask

    task automatic test_partial_abort();
        instruction = 8'h01; select = 3'b110;
        run_start(3'd5, 1'b0);
        sample(8'd1, 8'd1);
        checks++; if (rank_vld2 !== 2'b01) begin failures++;
            $display("FAIL partial_vld1 got=%b want=01", rank_vld2); end
        sample(8'd2, 8'd2);
        checks++; if (rank_vld2 !== 2'b11 || rank_out2 !== {8'd2, 8'd4}) begin failures++;
            $display("FAIL partial_vld2 got=%b/%h want=11/0204", rank_vld2, rank_out2); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin failures++;
            $display("FAIL partial_busy got busy=%b done=%b want 1/0", busy2, done2); end
        rst_n = 1'b0;
        tick();
        checks++; if ({busy2, done2, rank_vld2, rank_out2} !== 20'h0) begin failures++;
            $display("FAIL abort_reset got=%b %b %b %h want all zero", busy2, done2, rank_vld2, rank_out2); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin failures++;
                $display("FAIL abort_nodone cycle=%0d got done=%b busy=%b want 0/0", i, done2, busy2); end
        end
    endtask

    task automatic test_zero_count();
        run_start(3'd0, 1'b0);
        checks++; if (done2 !== 1'b1 || busy2 !== 1'b0 || rank_vld2 !== 2'b00) begin failures++;
            $display("FAIL zero_done got done=%b busy=%b vld=%b want 1/0/00", done2, busy2, rank_vld2); end
        tick();
        checks++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin failures++;
            $display("FAIL zero_after got done=%b busy=%b want 0/0", done2, busy2); end
    endtask

    task automatic test_ops();
        logic [7:0] t_instr [10] = '{8'hC5, 8'h40, 8'h03, 8'h00, 8'h08, 8'h04, 8'h20, 8'h20, 8'h10, 8'h17};
        logic [2:0] t_sel   [10] = '{3'b110, 3'b110, 3'b110, 3'b000, 3'b011, 3'b101, 3'b110, 3'b110, 3'b110, 3'b011};
        logic       t_sgn   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] t_exp   [10] = '{8'h06, 8'hC3, 8'h7D, 8'hC1, 8'h43, 8'h00, 8'h03, 8'h81, 8'h03, 8'h40};
        data_c = 8'h40;
        for (int i = 0; i < 10; i++) begin
            run_start(3'd1, t_sgn[i]);
            instruction = t_instr[i]; select = t_sel[i];
            sample(8'h81, 8'h03);
            checks++; if (done2 !== 1'b1 || rank_vld2 !== 2'b01 || rank_out2[7:0] !== t_exp[i]) begin failures++;
                $display("FAIL op_vec%0d got res=%h done=%b vld=%b want res=%h done=1 vld=01",
                         i, rank_out2[7:0], done2, rank_vld2, t_exp[i]); end
            tick();
        end
        data_c = 8'h00;
    endtask

    task automatic test_restart();
        instruction = 8'h01; select = 3'b110;
        run_start(3'd3, 1'b0);
        sample(8'h50, 8'h00);
        start = 1'b1; count = 3'd2; valid = 1'b1; data_a = 8'h63; data_b = 8'h00;
        tick();
        start = 1'b0; valid = 1'b0;
        checks++; if (rank_vld2 !== 2'b00 || busy2 !== 1'b1 || done2 !== 1'b0) begin failures++;
            $display("FAIL restart_clear got vld=%b busy=%b done=%b want 00/1/0", rank_vld2, busy2, done2); end
        sample(8'd7, 8'd0);
        sample(8'd9, 8'd0);
        checks++; if (done2 !== 1'b1 || rank_out2 !== {8'd7, 8'd9} || rank_vld2 !== 2'b11) begin failures++;
            $display("FAIL restart_done got done=%b rank=%h vld=%b want 1/0709/11", done2, rank_out2, rank_vld2); end
        sample(8'h70, 8'h00);
        checks++; if (rank_out2 !== {8'd7, 8'd9} || done2 !== 1'b0 || busy2 !== 1'b0) begin failures++;
            $display("FAIL idle_valid got rank=%h done=%b busy=%b want 0709/0/0", rank_out2, done2, busy2); end
        start = 1'b1; count = 3'd1; valid = 1'b1; data_a = 8'h70;
        tick();
        start = 1'b0; valid = 1'b0;
        checks++; if (rank_vld2 !== 2'b00 || busy2 !== 1'b1) begin failures++;
            $display("FAIL start_wins got vld=%b busy=%b want 00/1", rank_vld2, busy2); end
        sample(8'd5, 8'd0);
        checks++; if (done2 !== 1'b1 || rank_out2[7:0] !== 8'd5 || rank_vld2 !== 2'b01) begin failures++;
            $display("FAIL start_wins_done got done=%b rank=%h vld=%b want 1/05/01", done2, rank_out2[7:0], rank_vld2); end
        run_start(3'd1, 1'b0);
        checks++; if (busy2 !== 1'b1 || done2 !== 1'b0 || rank_vld2 !== 2'b00) begin failures++;
            $display("FAIL start_on_done got busy=%b done=%b vld=%b want 1/0/00", busy2, done2, rank_vld2); end
        sample(8'd6, 8'd0);
        checks++; if (done2 !== 1'b1 || rank_out2[7:0] !== 8'd6) begin failures++;
            $display("FAIL start_on_done_res got done=%b rank=%h want 1/06", done2, rank_out2[7:0]); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_signed();
        test_partial_abort();
        test_zero_count();
        test_ops();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
